// File: rtl/puf_key_scheduler.sv
// Drives eight 16-bit challenge words from a captured seed into the arbiter-PUF bank,
// majority-votes NUM_VOTES responses per word and assembles the 128-bit AES key.
module puf_key_scheduler #(
    parameter int unsigned NUM_VOTES     = 5,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic         clk_divided,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] seed,
    output logic [15:0]  challenge,
    input  logic [15:0]  response,
    output logic [127:0] key_out,
    output logic         key_valid,
    output logic         busy,
    output logic [7:0]   unstable_cnt
);

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned KEY_W     = 128;
    localparam int unsigned TALLY_W   = 4;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned WIDX_W    = 3;
    localparam int unsigned WUNST_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE
    } state_t;

    state_t                           state_q, state_d;
    logic [KEY_W-1:0]                 seed_q, seed_d;
    logic [WORD_W-1:0]                chal_q, chal_d;
    logic [KEY_W-1:0]                 key_q, key_d;
    logic                             valid_q, valid_d;
    logic                             busy_q, busy_d;
    logic [CNT_W-1:0]                 unst_q, unst_d;
    logic [WORD_W-1:0][TALLY_W-1:0]   tally_q, tally_d;
    logic [WIDX_W-1:0]                w_q, w_d;
    logic [TALLY_W-1:0]               v_q, v_d;
    logic [TALLY_W-1:0]               settle_q, settle_d;

    logic [WORD_W-1:0][TALLY_W-1:0]   tally_nxt;
    logic [WORD_W-1:0]                voted;
    logic [WUNST_W-1:0]               word_unst;
    logic [WIDX_W-1:0]                key_word;
    logic [WIDX_W-1:0]                next_word;

    // Per-bit vote accumulation and resolution of the word being sampled
    always_comb begin
        word_unst = '0;
        for (int i = 0; i < int'(WORD_W); i++) begin
            tally_nxt[i] = tally_q[i] + TALLY_W'(response[i]);
            voted[i]     = tally_nxt[i] > TALLY_W'(NUM_VOTES / 2);
            if (tally_nxt[i] != '0 && tally_nxt[i] != TALLY_W'(NUM_VOTES)) begin
                word_unst = word_unst + WUNST_W'(1);
            end
        end
        key_word  = WIDX_W'(7) - w_q;
        next_word = WIDX_W'(6) - w_q;
    end

    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        chal_d   = chal_q;
        key_d    = key_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        unst_d   = unst_q;
        tally_d  = tally_q;
        w_d      = w_q;
        v_d      = v_q;
        settle_d = settle_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_d   = seed;
                    chal_d   = seed[127:112];
                    w_d      = '0;
                    v_d      = '0;
                    tally_d  = '0;
                    unst_d   = '0;
                    valid_d  = 1'b0;
                    busy_d   = 1'b1;
                    settle_d = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (settle_q == TALLY_W'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + TALLY_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (v_q != TALLY_W'(NUM_VOTES - 1)) begin
                    tally_d = tally_nxt;
                    v_d     = v_q + TALLY_W'(1);
                    state_d = ST_WAIT;
                end else begin
                    // Last vote of this word: commit the majority and move on
                    key_d[{key_word, 4'b0000} +: WORD_W] = voted;
                    unst_d  = unst_q + CNT_W'(word_unst);
                    tally_d = '0;
                    v_d     = '0;
                    if (w_q != WIDX_W'(7)) begin
                        w_d     = w_q + WIDX_W'(1);
                        chal_d  = seed_q[{next_word, 4'b0000} +: WORD_W];
                        state_d = ST_WAIT;
                    end else begin
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_divided or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            seed_q   <= '0;
            chal_q   <= '0;
            key_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            unst_q   <= '0;
            tally_q  <= '0;
            w_q      <= '0;
            v_q      <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            chal_q   <= chal_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            unst_q   <= unst_d;
            tally_q  <= tally_d;
            w_q      <= w_d;
            v_q      <= v_d;
            settle_q <= settle_d;
        end
    end

    assign challenge    = chal_q;
    assign key_out      = key_q;
    assign key_valid    = valid_q;
    assign busy         = busy_q;
    assign unstable_cnt = unst_q;

endmodule

// File: tb/tb_puf_key_scheduler.sv
// Directed bench for puf_key_scheduler: default, single-vote and 15-vote instances
// driven by a PUF model (challenge ^ A5A5) with injectable noise on word 0 bit 0.
module tb_puf_key_scheduler;

    localparam logic [127:0] SEED0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] MASK  = {8{16'hA5A5}};

    typedef struct {
        logic [127:0] key;
        logic [7:0]   unst;
        int           lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        start;
    logic [127:0]      seed;
    logic [2:0][15:0]  chal;
    logic [2:0][15:0]  resp;
    logic [2:0][127:0] key;
    logic [2:0]        kv;
    logic [2:0]        bsy;
    logic [2:0][7:0]   unst;

    int   edges = 0;
    int   e0 = 0;
    int   cyc;
    logic [4:0] noise_votes = 5'b0;
    int   n_err = 0;
    int   n_chk = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    // PUF model; noise flips word-0 bit 0 on the selected votes of instance 0
    always_comb begin
        resp[0] = chal[0] ^ 16'hA5A5;
        resp[1] = chal[1] ^ 16'hA5A5;
        resp[2] = chal[2] ^ 16'hA5A5;
        cyc     = edges - e0;
        if (cyc >= 0 && cyc < 10 && noise_votes[cyc[3:1]]) resp[0][0] = ~resp[0][0];
    end

    puf_key_scheduler #(.NUM_VOTES(5), .SETTLE_CYCLES(1)) u_dut0 (
        .clk_divided(clk), .reset(reset), .start(start[0]), .seed(seed),
        .challenge(chal[0]), .response(resp[0]), .key_out(key[0]),
        .key_valid(kv[0]), .busy(bsy[0]), .unstable_cnt(unst[0]));

    puf_key_scheduler #(.NUM_VOTES(1), .SETTLE_CYCLES(1)) u_dut1 (
        .clk_divided(clk), .reset(reset), .start(start[1]), .seed(seed),
        .challenge(chal[1]), .response(resp[1]), .key_out(key[1]),
        .key_valid(kv[1]), .busy(bsy[1]), .unstable_cnt(unst[1]));

    puf_key_scheduler #(.NUM_VOTES(15), .SETTLE_CYCLES(3)) u_dut2 (
        .clk_divided(clk), .reset(reset), .start(start[2]), .seed(seed),
        .challenge(chal[2]), .response(resp[2]), .key_out(key[2]),
        .key_valid(kv[2]), .busy(bsy[2]), .unstable_cnt(unst[2]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_zero(input string tag, input int d);
        chk({tag, "_chal"}, 128'(chal[d]), 128'd0);
        chk({tag, "_key"},  key[d],        128'd0);
        chk({tag, "_unst"}, 128'(unst[d]), 128'd0);
        chk({tag, "_kv"},   128'(kv[d]),   128'd0);
        chk({tag, "_busy"}, 128'(bsy[d]),  128'd0);
    endtask

    task automatic launch(input int d, input logic [127:0] s, input logic [4:0] nv,
                          input logic [127:0] ek, input logic [7:0] eu, input int el,
                          input bit push);
        exp_t e;
        @(negedge clk);
        seed        = s;
        noise_votes = nv;
        start[d]    = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        e0       = edges;
        chk("accept_busy", 128'(bsy[d]),  128'd1);
        chk("accept_kv",   128'(kv[d]),   128'd0);
        chk("accept_chal", 128'(chal[d]), 128'(s[127:112]));
        if (push) begin
            e.key  = ek;
            e.unst = eu;
            e.lat  = el;
            sb.push_back(e);
        end
    endtask

    task automatic run_to_valid(input int d, input int pulse_a, input int pulse_b,
                                input bit chal_seq, input logic [127:0] s);
        int   n;
        int   w;
        bit   seen;
        bit   shape_ok;
        exp_t e;
        n        = 0;
        seen     = 1'b0;
        shape_ok = 1'b1;
        while (!seen && n < 1000) begin
            if (n + 1 == pulse_a || n + 1 == pulse_b) start[d] = 1'b1;
            @(posedge clk);
            #1;
            start[d] = 1'b0;
            n = edges - e0;
            if (kv[d]) begin
                seen = 1'b1;
                if (bsy[d]) shape_ok = 1'b0;
            end else if (!bsy[d]) begin
                shape_ok = 1'b0;
            end
            if (chal_seq && (n % 10) == 0) begin
                w = (n / 10 > 7) ? 7 : n / 10;
                chk("chal_seq", 128'(chal[d]), 128'(s[(7 - w) * 16 +: 16]));
            end
        end
        chk("valid_seen", 128'(seen), 128'd1);
        chk("busy_shape", 128'(shape_ok), 128'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 128'd0, 128'd1);
        end else begin
            e = sb.pop_front();
            chk("latency", 128'(n), 128'(e.lat));
            chk("key_out", key[d], e.key);
            chk("unstable_cnt", 128'(unst[d]), 128'(e.unst));
        end
    endtask

    initial begin
        logic [127:0] rs;
        reset = 1'b1;
        start = 3'b000;
        seed  = '0;
        repeat (2) @(negedge clk);
        chk_zero("por", 0);
        chk_zero("por1", 1);
        reset = 1'b0;

        // Abort a run with reset 20 edges in
        launch(0, SEED0, 5'b0, '0, '0, 0, 1'b0);
        repeat (20) @(posedge clk);
        #3;
        chk("pre_reset_busy", 128'(bsy[0]), 128'd1);
        reset = 1'b1;
        #1;
        chk_zero("mid_reset", 0);
        @(negedge clk);
        reset = 1'b0;

        // Stable PUF with challenge sequence check
        launch(0, SEED0, 5'b0, SEED0 ^ MASK, 8'd0, 80, 1'b1);
        run_to_valid(0, -1, -1, 1'b1, SEED0);

        // Back-to-back start at E0+81, noise below threshold, ignored pulses
        launch(0, SEED0, 5'b01010, SEED0 ^ MASK, 8'd1, 80, 1'b1);
        run_to_valid(0, 10, 50, 1'b0, SEED0);

        // Noise at threshold flips the voted bit
        launch(0, SEED0, 5'b10101, (SEED0 ^ MASK) ^ (128'd1 << 112), 8'd1, 80, 1'b1);
        run_to_valid(0, -1, -1, 1'b0, SEED0);

        // Parameter corners
        launch(1, SEED0, 5'b0, SEED0 ^ MASK, 8'd0, 16, 1'b1);
        run_to_valid(1, -1, -1, 1'b0, SEED0);
        rs = {$urandom, $urandom, $urandom, $urandom};
        launch(2, rs, 5'b0, rs ^ MASK, 8'd0, 480, 1'b1);
        run_to_valid(2, -1, -1, 1'b0, rs);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/puf_key_scheduler.md
# puf_key_scheduler

Sequencing controller for the shared 16-bit arbiter-PUF response bank in the AES key path. It walks a 128-bit seed as eight 16-bit challenge words and repeats each challenge NUM_VOTES times. Each response bit is majority-voted, and the voted words are assembled into a 128-bit AES key. It runs on the divided PUF clock, uses a start/busy/key_valid handshake toward the AES core, and reports how many key bits were not unanimous.

## Interface
- NUM_VOTES, 5: responses sampled per challenge word; odd, 1..15.
- SETTLE_CYCLES, 1: clk_divided cycles the challenge is held before each response sample; 1..15.
- clk_divided  in  1  divided PUF clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  request key generation; sampled only in IDLE.
- seed  in  128  challenge source; captured on start acceptance; word 0 = [127:112] ... word 7 = [15:0].
- challenge  out  16  challenge driven to the PUF bank.
- response  in  16  PUF bank response; bit i answers the current challenge.
- key_out  out  128  voted key; word w written to the same bit slice as seed word w.
- key_valid  out  1  key_out complete and stable.
- busy  out  1  generation in progress.
- unstable_cnt  out  8  count of key bits whose votes were not unanimous (0..128).

## Operation
- States: IDLE, WAIT, SAMPLE.
- IDLE, start=1 (accepted):
  - capture seed; challenge <= word 0; w <= 0, v <= 0;
  - clear the 16 per-bit tallies (4 bits each) and unstable_cnt; key_valid <= 0, busy <= 1;
  - go to WAIT with settle counter = 0.
- WAIT: hold challenge for SETTLE_CYCLES edges, then go to SAMPLE.
- SAMPLE, one edge: tally_next[i] = tally[i] + response[i].
  - v < NUM_VOTES-1:
    - tally <= tally_next; v++;
    - back to WAIT; challenge unchanged.
  - v = NUM_VOTES-1, resolve word w:
    - key bit i = (tally_next[i] > NUM_VOTES/2), using integer division.
    - unstable_cnt += number of i with tally_next[i] not 0 and not NUM_VOTES.
    - Clear tallies; v <= 0.
    - w < 7: w++; challenge <= word w+1; go to WAIT.
    - w = 7: challenge holds word 7; busy <= 0; key_valid <= 1; go to IDLE.
- key_valid stays high until the next accepted start, which clears it on the accepting edge.
- start while busy is ignored; a pulse is not queued.
- key_out words not yet resolved keep their previous value during a run. Consumers use key_out only while key_valid=1.
- Reset at any time:
  - asynchronously forces IDLE;
  - challenge, key_out and unstable_cnt = 0; key_valid = 0, busy = 0;
  - clears tallies, w and v.
  - The first start after reset deassertion is accepted normally.

## Timing
- E0 = edge accepting start; challenge = word 0 after E0.
- One vote takes SETTLE_CYCLES+1 edges.
- key_valid rises on edge E0 + 8·NUM_VOTES·(SETTLE_CYCLES+1):
  - 80 for the defaults;
  - 16 for NUM_VOTES=1, SETTLE_CYCLES=1.
- response is sampled only on SAMPLE edges. The PUF bank must settle within SETTLE_CYCLES edges of a challenge change.
- challenge changes only on E0 and on the final SAMPLE edge of words 0..6.
- busy is 1 from E0 through the key_valid edge; busy and key_valid are never both 1.
- The earliest new start acceptance is the edge after key_valid rises.

## Test plan
- Reset values: assert reset mid-run, 20 edges after E0 with defaults -> all outputs 0 at once; state IDLE. Deassert, start -> full 80-edge run completes correctly.
- Stable PUF: model response = challenge ^ 16'hA5A5; seed = 128'h0123456789ABCDEF_FEDCBA9876543210 -> key_out = seed ^ {8{16'hA5A5}}; unstable_cnt = 0; key_valid at E0+80; challenge sequence 0123, 4567, 89AB, CDEF, FEDC, BA98, 7654, 3210.
- Noise below threshold: same model, bit 0 of word 0 inverted on votes 1 and 3 of 5 -> key_out unchanged from the stable result; unstable_cnt = 1.
- Noise at threshold: bit 0 of word 0 inverted on votes 0, 2 and 4 -> key_out[112] inverted vs. the stable result; unstable_cnt = 1.
- Handshake:
  - start pulses at E0+10 and E0+50 -> ignored; single run ends at E0+80.
  - start at E0+81 -> key_valid falls on that edge; busy rises; new key at E0+161.
- Parameter corner: NUM_VOTES=1, SETTLE_CYCLES=1, stable model -> key_valid at E0+16; unstable_cnt = 0. NUM_VOTES=15, SETTLE_CYCLES=3 -> key_valid at E0+480.
